// File: rtl/servo_pkg.sv
// Shared widths, default limits and FSM state encoding for the servo pulse decoder.
package servo_pkg;

    localparam int DUTY_W         = 7;
    localparam int PERIOD_W       = 8;
    localparam int TICK_DIV_DEF   = 500;
    localparam int HIGH_MAX_DEF   = 25;
    localparam int PERIOD_MAX_DEF = 120;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_HIGH      = 3'd3;
    localparam logic [2:0] ST_LOW       = 3'd4;

endpackage

// File: rtl/servo_tick_gen.sv
// Measurement prescaler: one-cycle tick every TICK_DIV clocks, realigned by clr.
module servo_tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM decoder: measures high time and rise-to-rise period in prescaler ticks.
// Define SERVO_DEC_GLITCH_FILTER_EN to add a 2-cycle stability filter on the input.
//
// state     | meaning
// IDLE      | disabled, counters cleared
// WAIT_LOW  | wait for input low so no partial pulse is measured
// WAIT_RISE | wait for first rise, period limit still timed
// HIGH      | counting high time and period
// LOW       | counting period, next rise publishes the measurement
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int HIGH_MAX   = HIGH_MAX_DEF,
    parameter int PERIOD_MAX = PERIOD_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                senal,
    output logic [DUTY_W-1:0]   duty,
    output logic [PERIOD_W-1:0] period,
    output logic                valid,
    output logic                err,
    output logic                lost
);

    localparam logic [DUTY_W-1:0]   HIGH_LIM = DUTY_W'(HIGH_MAX);
    localparam logic [PERIOD_W-1:0] PER_LIM  = PERIOD_W'(PERIOD_MAX);

    logic sync1, sync2, sync2_d;
    logic cur_lvl, prev_lvl, rise, fall;
    logic tick;

    state_t              state, state_n;
    logic [DUTY_W-1:0]   high_cnt, high_n, high_inc;
    logic [PERIOD_W-1:0] period_cnt, per_n, per_inc;
    logic [DUTY_W-1:0]   duty_n;
    logic [PERIOD_W-1:0] period_n;
    logic                valid_n, err_n, lost_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= senal;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    logic filt;

    // Follow the synchronized input only once it has held for two samples.
    assign cur_lvl  = (sync2 == sync2_d) ? sync2 : filt;
    assign prev_lvl = filt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
        end else begin
            filt <= cur_lvl;
        end
    end
`else
    assign cur_lvl  = sync2;
    assign prev_lvl = sync2_d;
`endif

    assign rise = cur_lvl & ~prev_lvl;
    assign fall = ~cur_lvl & prev_lvl;

    servo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (rise | ~en),
        .tick  (tick)
    );

    // A tick landing on the closing edge still belongs to the interval it ends.
    assign high_inc = high_cnt + DUTY_W'(tick);
    assign per_inc  = period_cnt + PERIOD_W'(tick);

    always_comb begin
        state_n  = state;
        high_n   = high_cnt;
        per_n    = period_cnt;
        duty_n   = duty;
        period_n = period;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        lost_n   = lost;
        if (!en) begin
            state_n = ST_IDLE;
            high_n  = '0;
            per_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    high_n = '0;
                    per_n  = '0;
                    if (!cur_lvl) state_n = ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    high_n = '0;
                    if (rise) begin
                        state_n = ST_HIGH;
                        per_n   = '0;
                    end else if (per_inc == PER_LIM) begin
                        lost_n = 1'b1;
                        per_n  = '0;
                    end else begin
                        per_n = per_inc;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_n = ST_LOW;
                        high_n  = high_inc;
                        per_n   = per_inc;
                    end else if (high_inc == HIGH_LIM) begin
                        state_n = ST_WAIT_LOW;
                        err_n   = 1'b1;
                        high_n  = '0;
                        per_n   = '0;
                    end else if (per_inc == PER_LIM) begin
                        state_n = ST_WAIT_RISE;
                        lost_n  = 1'b1;
                        high_n  = '0;
                        per_n   = '0;
                    end else begin
                        high_n = high_inc;
                        per_n  = per_inc;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_n  = ST_HIGH;
                        duty_n   = high_cnt;
                        period_n = per_inc;
                        valid_n  = 1'b1;
                        lost_n   = 1'b0;
                        high_n   = '0;
                        per_n    = '0;
                    end else if (per_inc == PER_LIM) begin
                        state_n = ST_WAIT_RISE;
                        lost_n  = 1'b1;
                        high_n  = '0;
                        per_n   = '0;
                    end else begin
                        per_n = per_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    high_n  = '0;
                    per_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty       <= '0;
            period     <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            lost       <= 1'b1;
        end else begin
            state      <= state_n;
            high_cnt   <= high_n;
            period_cnt <= per_n;
            duty       <= duty_n;
            period     <= period_n;
            valid      <= valid_n;
            err        <= err_n;
            lost       <= lost_n;
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with a scoreboard of expected measurements.
module tb_servo_pulse_decoder;

    localparam int TD = 4;
    localparam int HM = 25;
    localparam int PM = 120;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int duty;
        int period;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       senal = 1'b0;
    logic [6:0] duty;
    logic [7:0] period;
    logic       valid, err, lost;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   valid_seen = 0;
    int   err_seen = 0;
    int   prev_hi = 0;
    int   prev_lo = 0;
    int   last_rise = 0;
    int   n_valid = 0;
    exp_t exp_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   mon_c;

    servo_pulse_decoder #(
        .TICK_DIV   (TD),
        .HIGH_MAX   (HM),
        .PERIOD_MAX (PM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .senal  (senal),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .err    (err),
        .lost   (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rise now; if this rise closes a measured period, its result is due LAT cycles later.
    task automatic send(input int hi, input int lo, input bit closes, input bit spiky);
        if (closes) exp_q.push_back('{prev_hi / TD, (prev_hi + prev_lo) / TD, cyc + LAT});
        last_rise = cyc;
        senal = 1'b1;
        repeat (hi) step();
        for (int i = 0; i < lo; i++) begin
            senal = spiky && (i == 100 || i == 200);
            step();
        end
        senal = 1'b0;
        prev_hi = hi;
        prev_lo = lo;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            valid_seen++;
            chk("valid_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("duty", duty, mon_e.duty);
                chk("period", period, mon_e.period);
                chk("valid_cycle", cyc, mon_e.due);
            end
        end
        if (err) begin
            err_seen++;
            chk("err_expected", 32'(err_q.size() > 0), 1);
            if (err_q.size() > 0) begin
                mon_c = err_q.pop_front();
                chk("err_cycle", cyc, mon_c);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_duty", duty, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_lost", lost, 1);

        reset = 1'b1;
        en = 1'b1;
        repeat (5) step();

        send(28, 372, 0, 0);
        send(28, 372, 1, 0);
        send(28, 372, 1, 0);
        chk("lost_cleared", lost, 0);

        send(36, 364, 1, 0);
        send(36, 364, 1, 0);

        // Overlong pulse: err at tick HM, then one full period before results resume.
        err_q.push_back(cyc + LAT + HM * TD);
        send(120, 280, 1, 0);
        send(28, 372, 0, 0);
        send(28, 372, 1, 0);

        while (cyc < last_rise + LAT + TD * PM - 1) step();
        chk("lost_before_limit", lost, 0);
        step();
        chk("lost_at_limit", lost, 1);
        chk("hold_duty", duty, 7);
        chk("hold_period", period, 100);
        send(28, 372, 0, 0);
        chk("lost_first_rise", lost, 1);
        send(28, 372, 1, 0);
        chk("lost_recovered", lost, 0);

`ifdef SERVO_DEC_GLITCH_FILTER_EN
        send(28, 372, 1, 1);
        send(28, 372, 1, 0);
`endif

        en = 1'b0;
        step();
        n_valid = valid_seen;
        send(28, 372, 0, 0);
        send(28, 372, 0, 0);
        chk("no_valid_disabled", valid_seen, n_valid);
        chk("dis_hold_duty", duty, 7);
        en = 1'b1;
        repeat (3) step();
        send(28, 372, 0, 0);
        send(28, 372, 1, 0);

        exp_q.push_back('{prev_hi / TD, (prev_hi + prev_lo) / TD, cyc + LAT});
        senal = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        #1;
        chk("midrst_duty", duty, 0);
        chk("midrst_period", period, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_lost", lost, 1);
        senal = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        prev_hi = 0;
        prev_lo = 0;
        send(32, 368, 0, 0);
        send(28, 372, 1, 0);
        repeat (10) step();

        chk("exp_q_drained", exp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("err_count", err_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pulse_decoder.md
SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500, clk cycles per measurement tick (1 tick = 1 duty unit).
REQ-002 SHALL have parameter HIGH_MAX, default 25, high-time limit in ticks.
REQ-003 SHALL have parameter PERIOD_MAX, default 120, rise-to-rise limit in ticks.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  decoder enable; low holds FSM in IDLE.
REQ-007 SHALL have port senal  input  1  servo PWM pulse train, asynchronous to clk.
REQ-008 SHALL have port duty  output  7  last measured high time in ticks.
REQ-009 SHALL have port period  output  8  last measured rise-to-rise time in ticks.
REQ-010 SHALL have port valid  output  1  one-cycle strobe when duty/period update.
REQ-011 SHALL have port err  output  1  one-cycle strobe on high-time overrun.
REQ-012 SHALL have port lost  output  1  level; no complete pulse within PERIOD_MAX.

Function
REQ-013 SHALL synchronize senal through 2 flops; rise/fall detected by comparing the synchronized value with its previous-cycle value.
REQ-014 SHALL generate a tick every TICK_DIV clk cycles; the prescaler restarts at 0 on every detected rise, so counts are aligned to the pulse.
REQ-015 SHALL implement FSM states IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW.
REQ-016 IDLE -> WAIT_LOW when en=1; any state -> IDLE, counters cleared, when en=0.
REQ-017 WAIT_LOW -> WAIT_RISE when synchronized input is 0 (no mid-pulse measurement after start).
REQ-018 WAIT_RISE -> HIGH on rise; high_cnt and period_cnt cleared to 0.
REQ-019 HIGH: high_cnt and period_cnt +1 per tick; on fall -> LOW; if high_cnt reaches HIGH_MAX -> err=1 for one cycle, measurement discarded, -> WAIT_LOW.
REQ-020 LOW: period_cnt +1 per tick; on rise -> duty<=high_cnt, period<=period_cnt, valid=1 one cycle, lost<=0, counters cleared, stay measuring (-> HIGH).
REQ-021 In HIGH, LOW or WAIT_RISE, period_cnt reaching PERIOD_MAX SHALL set lost=1 and go to WAIT_RISE; in WAIT_RISE the limit is timed by the same counter.
REQ-022 duty and period SHALL hold their last values while lost=1 or en=0.
REQ-023 Rise and limit in the same cycle: rise wins (measurement published, no lost).
REQ-024 Latency: valid asserted exactly 3 clk cycles after the senal rising edge that closes a period (4 with filter, REQ-030).
REQ-025 Counters SHALL be wide enough never to wrap before their limits; high_cnt fits 7 bits, period_cnt 8 bits.

Reset
REQ-026 On reset=0: FSM=IDLE; duty=0, period=0, valid=0, err=0, lost=1; sync flops, prescaler, counters=0.
REQ-027 Reset mid-pulse SHALL discard the partial measurement; after release the first published value needs one full WAIT_LOW/WAIT_RISE cycle.

Configuration
REQ-028 Macro SERVO_DEC_GLITCH_FILTER_EN SHALL select an input glitch filter.
REQ-029 Without it: synchronized input drives edge detection directly.
REQ-030 With it: filtered level changes only after the synchronized input is stable for 2 consecutive clk cycles; pulses of 1 clk cycle are ignored; adds 1 cycle of latency.

Structure
REQ-031 Package servo_pkg SHALL hold FSM state typedef, DUTY_W=7, PERIOD_W=8 and default limit constants.
REQ-032 The prescaler SHALL be a sub-module servo_tick_gen (clk, reset, clr, tick).

Verification (TICK_DIV=4, HIGH_MAX=25, PERIOD_MAX=120)
REQ-033 Pulse train 28 clk high / 372 clk low, repeated -> 2nd rise onward: valid, duty=7, period=100, lost=0.
REQ-034 Change to 36 clk high, same period -> next valid after the first changed pulse gives duty=9, period=100.
REQ-035 Hold senal high 120 clk -> err strobe at tick 25, no valid; then normal train -> resumes after one full period.
REQ-036 Stop pulses (senal=0) -> lost=1 at period_cnt=120; duty/period hold last values; next two rises -> valid, lost=0.
REQ-037 reset=0 mid-HIGH -> all outputs at reset values immediately; en=0 -> no valid while pulses continue.
REQ-038 With SERVO_DEC_GLITCH_FILTER_EN: 1-clk spikes in the low phase -> no change to duty/period; valid 4 cycles after the rise.
